// File: rtl/sram_array_ctrl.sv
`default_nettype none
// ============================================================================
// sram_array_ctrl : single-port SRAM array, masked writes, 1-cycle read,
//                   init sweep after reset/clear, out-of-range detection
// Rev 1.0
// ============================================================================
module sram_array_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_wmask,
   input  logic              clear_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              init_busy,
   output logic              addr_err
);

   localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                addr_err_q, addr_err_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                w_accept;
   logic                w_in_range;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_waddr;
   logic [DATA_W-1:0]   w_mem_wdata;

   // Ready depends only on state and clear_req so a clear always wins the cycle
   assign req_ready  = (state_q == ST_READY) && !clear_req;
   assign init_busy  = (state_q == ST_INIT);
   assign w_accept   = req_valid && req_ready;
   assign w_in_range = ({1'b0, req_addr} < c_depth);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
      addr_err_d  = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_waddr = cnt_q;
      w_mem_wdata = '0;

      case (state_q)
         ST_INIT: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = cnt_q;
            w_mem_wdata = '0;
            if (cnt_q == c_last) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_READY: begin
            if (clear_req) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end else if (w_accept) begin
               addr_err_d = !w_in_range;
               if (req_we) begin
                  if (w_in_range) begin
                     w_mem_we    = 1'b1;
                     w_mem_waddr = req_addr;
                     w_mem_wdata = (mem_q[req_addr] & ~req_wmask) |
                                   (req_wdata & req_wmask);
                  end
               end else begin
                  rd_valid_d = 1'b1;
                  // Out-of-range reads still complete, returning zero
                  rd_data_d  = w_in_range ? mem_q[req_addr] : '0;
               end
            end
         end

         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Storage has no reset; the sweep is what clears it
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem_q[w_mem_waddr] <= w_mem_wdata;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign addr_err = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_array_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sram_array_ctrl : two instances (64 and 48 words) checked against an
//                      array model with directed and random requests
// Rev 1.0
// ============================================================================
module tb_sram_array_ctrl;

   localparam int c_dw = 8;
   localparam int c_aw = 6;

   logic clk = 1'b0;
   logic reset_n;

   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [1:0]           req_we;
   logic [1:0][c_aw-1:0] req_addr;
   logic [1:0][c_dw-1:0] req_wdata;
   logic [1:0][c_dw-1:0] req_wmask;
   logic [1:0]           clear_req;
   logic [1:0]           rd_valid;
   logic [1:0][c_dw-1:0] rd_data;
   logic [1:0]           init_busy;
   logic [1:0]           addr_err;

   logic [c_dw-1:0] model  [2][64];
   logic [c_dw-1:0] exp_rd [2];
   int              depth  [2] = '{64, 48};

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sram_array_ctrl #(.DATA_W(c_dw), .ADDR_W(c_aw), .DEPTH(64)) u_dut64 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
      .clear_req(clear_req[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
      .init_busy(init_busy[0]), .addr_err(addr_err[0])
   );

   sram_array_ctrl #(.DATA_W(c_dw), .ADDR_W(c_aw), .DEPTH(48)) u_dut48 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
      .clear_req(clear_req[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
      .init_busy(init_busy[1]), .addr_err(addr_err[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input int u);
      for (int i = 0; i < 64; i++) model[u][i] = '0;
   endtask

   task automatic chk_reset_outputs(input int u, input string tag);
      chk({tag, " init_busy"}, 32'(init_busy[u]), 32'd1);
      chk({tag, " req_ready"}, 32'(req_ready[u]), 32'd0);
      chk({tag, " rd_valid"},  32'(rd_valid[u]),  32'd0);
      chk({tag, " rd_data"},   32'(rd_data[u]),   32'd0);
      chk({tag, " addr_err"},  32'(addr_err[u]),  32'd0);
   endtask

   // Called on the negedge where reset_n is released; counts busy cycles per unit
   task automatic sweep_wait(input string tag);
      int busy0 = 0;
      int busy1 = 0;
      int bad   = 0;
      for (int k = 0; k < 100; k++) begin
         busy0 += int'(init_busy[0]);
         busy1 += int'(init_busy[1]);
         if (init_busy[0] && req_ready[0]) bad++;
         if (init_busy[1] && req_ready[1]) bad++;
         @(negedge clk);
      end
      chk({tag, " busy64"}, 32'(busy0), 32'd64);
      chk({tag, " busy48"}, 32'(busy1), 32'd48);
      chk({tag, " ready during init"}, 32'(bad), 32'd0);
   endtask

   // Starts on a negedge, returns on the negedge after the accepting edge
   task automatic xfer(input int u, input bit we, input logic [c_aw-1:0] a,
                       input logic [c_dw-1:0] d, input logic [c_dw-1:0] m,
                       input string tag);
      int n = 0;
      bit inr;
      inr = (int'(a) < depth[u]);
      req_we[u]    = we;
      req_addr[u]  = a;
      req_wdata[u] = d;
      req_wmask[u] = m;
      req_valid[u] = 1'b1;
      while (!req_ready[u] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " accept"}, 32'(n < 300), 32'd1);
      @(negedge clk);
      req_valid[u] = 1'b0;
      if (we && inr) model[u][a] = (model[u][a] & ~m) | (d & m);
      if (!we) exp_rd[u] = inr ? model[u][a] : '0;
      chk({tag, " rd_valid"}, 32'(rd_valid[u]), 32'(!we));
      chk({tag, " rd_data"},  32'(rd_data[u]),  32'(exp_rd[u]));
      chk({tag, " addr_err"}, 32'(addr_err[u]), 32'(!inr));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int busy;
      reset_n   = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      clear_req = '0;
      for (int u = 0; u < 2; u++) begin
         model_clear(u);
         exp_rd[u] = '0;
      end

      // Reset and first sweep
      #2 reset_n = 1'b0;
      #1;
      chk_reset_outputs(0, "reset64");
      chk_reset_outputs(1, "reset48");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      sweep_wait("sweep1");
      xfer(0, 1'b0, 6'h3F, 8'h00, 8'h00, "rd 3F after sweep");

      // Masked write merge
      xfer(0, 1'b1, 6'd5, 8'hA5, 8'hFF, "wr5 A5");
      xfer(0, 1'b1, 6'd5, 8'h0F, 8'h0F, "wr5 0F/0F");
      xfer(0, 1'b0, 6'd5, 8'h00, 8'h00, "rd5 merged");
      chk("rd5 value", 32'(rd_data[0]), 32'h0000_00AF);
      xfer(0, 1'b1, 6'd5, 8'hFF, 8'h00, "wr5 mask0");
      xfer(0, 1'b0, 6'd5, 8'h00, 8'h00, "rd5 mask0");

      // Back-to-back reads
      xfer(0, 1'b1, 6'd10, 8'h3C, 8'hFF, "wr10");
      req_we[0]    = 1'b0;
      req_addr[0]  = 6'd10;
      req_valid[0] = 1'b1;
      @(negedge clk);
      chk("b2b first rd_valid", 32'(rd_valid[0]), 32'd1);
      chk("b2b first rd_data",  32'(rd_data[0]),  32'(model[0][10]));
      req_addr[0] = 6'd11;
      @(negedge clk);
      req_valid[0] = 1'b0;
      exp_rd[0]    = model[0][11];
      chk("b2b second rd_valid", 32'(rd_valid[0]), 32'd1);
      chk("b2b second rd_data",  32'(rd_data[0]),  32'(exp_rd[0]));
      @(negedge clk);
      chk("b2b idle rd_valid", 32'(rd_valid[0]), 32'd0);
      chk("b2b hold rd_data",  32'(rd_data[0]),  32'(exp_rd[0]));

      // Out-of-range on the 48-word instance
      xfer(1, 1'b1, 6'd50, 8'hFF, 8'hFF, "oor wr50");
      xfer(1, 1'b0, 6'd50, 8'h00, 8'h00, "oor rd50");
      xfer(1, 1'b0, 6'd47, 8'h00, 8'h00, "rd47");
      xfer(1, 1'b1, 6'd47, 8'h77, 8'hFF, "wr47");
      xfer(1, 1'b0, 6'd47, 8'h00, 8'h00, "rd47 back");

      // Random traffic on both instances
      for (int i = 0; i < 150; i++) begin
         int u;
         logic [c_dw-1:0] m;
         u = int'($urandom_range(0, 1));
         m = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         xfer(u, 1'($urandom), 6'($urandom), 8'($urandom), m, "rand");
      end

      // clear_req beats a simultaneous read; the read waits out the sweep
      xfer(0, 1'b1, 6'd5, 8'hA5, 8'hFF, "wr5 pre-clear");
      clear_req[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 6'd5;
      req_valid[0] = 1'b1;
      #1;
      chk("clear ready low", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      clear_req[0] = 1'b0;
      model_clear(0);
      chk("clear no accept", 32'(rd_valid[0]), 32'd0);
      n    = 0;
      busy = 0;
      while (!req_ready[0] && n < 300) begin
         busy += int'(init_busy[0]);
         @(negedge clk);
         n++;
      end
      chk("clear busy cycles", 32'(busy), 32'd64);
      @(negedge clk);
      req_valid[0] = 1'b0;
      exp_rd[0]    = model[0][5];
      chk("clear pending rd_valid", 32'(rd_valid[0]), 32'd1);
      chk("clear pending rd_data",  32'(rd_data[0]),  32'(exp_rd[0]));

      // Asynchronous reset with a read result on the outputs
      xfer(0, 1'b1, 6'd20, 8'h5A, 8'hFF, "wr20");
      xfer(0, 1'b0, 6'd20, 8'h00, 8'h00, "rd20");
      #2 reset_n = 1'b0;
      #1;
      chk_reset_outputs(0, "async reset ready");
      @(negedge clk);
      reset_n = 1'b1;
      for (int u = 0; u < 2; u++) begin
         model_clear(u);
         exp_rd[u] = '0;
      end

      // Reset again part way through the sweep; the sweep restarts in full
      repeat (20) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk_reset_outputs(0, "async reset sweep");
      @(negedge clk);
      reset_n = 1'b1;
      sweep_wait("sweep restart");
      xfer(0, 1'b0, 6'd20, 8'h00, 8'h00, "rd20 after reset");
      xfer(0, 1'b0, 6'd10, 8'h00, 8'h00, "rd10 after reset");

      for (int i = 0; i < 40; i++) begin
         int u;
         u = int'($urandom_range(0, 1));
         xfer(u, 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), "rand2");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
